// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one instruction-memory
// read at a time over req/ack + valid, buffers returned words with their PCs
// in a small FIFO and presents the head entry to the IF/ID register.
module fetch_stage #(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0] PC_RESET       = '0,
    parameter logic [DATA_BIT_WIDTH-1:0] PC_STEP        = DATA_BIT_WIDTH'(4),
    parameter int                        BUF_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [DATA_BIT_WIDTH-1:0] redirectPC,
    output logic                      imemReq,
    output logic [DATA_BIT_WIDTH-1:0] imemAddr,
    input  logic                      imemAck,
    input  logic                      imemValid,
    input  logic [DATA_BIT_WIDTH-1:0] imemData,
    output logic                      fetchValid,
    output logic [DATA_BIT_WIDTH-1:0] fetchPC,
    output logic [DATA_BIT_WIDTH-1:0] fetchInstr
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,     // no request outstanding
        ST_REQ,      // imemReq high, waiting for ack
        ST_WAIT,     // acked, waiting for the response
        ST_DISCARD   // acked, response belongs to a flushed path
    } state_t;

    state_t                    r_state, w_state_next;
    logic [DATA_BIT_WIDTH-1:0] r_next_pc, w_next_pc_d;
    logic [DATA_BIT_WIDTH-1:0] r_imem_addr, w_addr_d;
    logic                      r_imem_req, w_req_d;

    logic [DATA_BIT_WIDTH-1:0] r_buf_pc    [BUF_DEPTH];
    logic [DATA_BIT_WIDTH-1:0] r_buf_instr [BUF_DEPTH];
    logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             w_count_push;
    logic                      w_push, w_pop, w_fetch_valid;

    assign w_fetch_valid = (r_count != '0);
    // A redirect flushes the FIFO, so the head is not consumed that cycle.
    assign w_pop         = w_fetch_valid & ~stall & ~redirect;
    // Occupancy after a push this cycle, used to decide whether to re-request.
    assign w_count_push  = r_count + CW'(1) - CW'(w_pop);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state, request and PC decode; redirect takes priority everywhere.
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        w_next_pc_d  = r_next_pc;
        w_req_d      = r_imem_req;
        w_addr_d     = r_imem_addr;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_state_next = ST_REQ;
                    w_req_d      = 1'b1;
                    w_addr_d     = redirectPC;
                    w_next_pc_d  = redirectPC;
                end else if (r_count < DEPTH_C) begin
                    w_state_next = ST_REQ;
                    w_req_d      = 1'b1;
                    w_addr_d     = r_next_pc;
                end
            end
            ST_REQ: begin
                if (imemAck) begin
                    w_req_d = 1'b0;
                    if (redirect) begin
                        w_state_next = ST_DISCARD;
                        w_next_pc_d  = redirectPC;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_next_pc_d  = r_next_pc + PC_STEP;
                    end
                end else if (redirect) begin
                    // Unacked request may be retargeted in place.
                    w_addr_d    = redirectPC;
                    w_next_pc_d = redirectPC;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_next_pc_d = redirectPC;
                    if (imemValid) begin
                        w_state_next = ST_REQ;
                        w_req_d      = 1'b1;
                        w_addr_d     = redirectPC;
                    end else begin
                        w_state_next = ST_DISCARD;
                    end
                end else if (imemValid) begin
                    w_push = 1'b1;
                    if (w_count_push < DEPTH_C) begin
                        w_state_next = ST_REQ;
                        w_req_d      = 1'b1;
                        w_addr_d     = r_next_pc;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                // The stale response is dropped; the FIFO was flushed on entry,
                // so there is always room to restart immediately. A response
                // arriving together with a further redirect ends the discard too,
                // otherwise the stage would wait for a response that never comes.
                if (redirect) begin
                    w_next_pc_d = redirectPC;
                    if (imemValid) begin
                        w_state_next = ST_REQ;
                        w_req_d      = 1'b1;
                        w_addr_d     = redirectPC;
                    end
                end else if (imemValid) begin
                    w_state_next = ST_REQ;
                    w_req_d      = 1'b1;
                    w_addr_d     = r_next_pc;
                end
            end
            default: ;
        endcase
    end

    // Registered memory request and fetch PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_next_pc   <= PC_RESET;
        end else begin
            r_imem_req  <= w_req_d;
            r_imem_addr <= w_addr_d;
            r_next_pc   <= w_next_pc_d;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage: the issued address travels with its returned word.
    // NOTE: storage is not reset; entries are only observed through the valid count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_imem_addr;
            r_buf_instr[r_wr_ptr] <= imemData;
        end
    end

    assign imemReq    = r_imem_req;
    assign imemAddr   = r_imem_addr;
    assign fetchValid = w_fetch_valid;
    assign fetchPC    = w_fetch_valid ? r_buf_pc[r_rd_ptr]    : '0;
    assign fetchInstr = w_fetch_valid ? r_buf_instr[r_rd_ptr] : '0;

endmodule
